// File: rtl/smp_mem_pkg.sv
// Shared constants for the two-port system-memory arbiter.
package smp_mem_pkg;

    localparam int unsigned DEF_ADDR_W     = 16;
    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_ACCESS_CYC = 1;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t SETUP  = 2'd1;
    localparam state_t ACCESS = 2'd2;
    localparam state_t DONE   = 2'd3;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DATA   = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin winner select; last_grant advances only when a grant is taken.
module rr_arbiter_2
    import smp_mem_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic       win
);

    logic last_grant;

    // Lone requester wins; on contention the port not served last wins
    always_comb begin
        win = PORT_IFETCH;
        case (req)
            2'b10:   win = PORT_DATA;
            2'b11:   win = ~last_grant;
            default: win = PORT_IFETCH;
        endcase
    end

    // Remember the last winner; reset points at port 1 so port 0 goes first
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= PORT_DATA;
        end else if (take) begin
            last_grant <= win;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Sequences instruction-fetch and load/store accesses onto the shared 64K x 8 memory.
module mem_bus_arbiter
    import smp_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned ACCESS_CYC = DEF_ACCESS_CYC
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_we,
    output logic              mem_MEMbus,
    output logic              mem_BUSmem,
    output logic [DATA_W-1:0] bus_dout,
    output logic              bus_oe,
    input  logic [DATA_W-1:0] bus_din
);

    localparam int unsigned CNT_W = $clog2(ACCESS_CYC + 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               take;
    logic               win;

    logic               lat_port, nxt_port;
    logic               lat_we,   nxt_we;
    logic [ADDR_W-1:0]  lat_addr, nxt_addr;
    logic [DATA_W-1:0]  lat_wdata, nxt_wdata;

    logic               gnt0_d, gnt1_d, ack0_d, ack1_d;
    logic               mem_we_d, mem_MEMbus_d, mem_BUSmem_d, bus_oe_d;
    logic [ADDR_W-1:0]  mem_address_d;
    logic [DATA_W-1:0]  bus_dout_d;

    assign take = (state == IDLE) && (req0 || req1);

    rr_arbiter_2 u_rr (
        .clock (clock),
        .reset (reset),
        .req   ({req1, req0}),
        .take  (take),
        .win   (win)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: IDLE -> SETUP -> ACCESS (ACCESS_CYC cycles) -> DONE -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request payload as it will be held for the transaction (fresh copy at grant)
    always_comb begin
        nxt_port  = lat_port;
        nxt_we    = lat_we;
        nxt_addr  = lat_addr;
        nxt_wdata = lat_wdata;
        if (take) begin
            nxt_port  = win;
            nxt_we    = win ? we1    : we0;
            nxt_addr  = win ? addr1  : addr0;
            nxt_wdata = win ? wdata1 : wdata0;
        end
    end

    // Latched request and ACCESS down-counter
    always_ff @(posedge clock) begin
        if (reset) begin
            lat_port  <= PORT_IFETCH;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= '0;
        end else begin
            lat_port  <= nxt_port;
            lat_we    <= nxt_we;
            lat_addr  <= nxt_addr;
            lat_wdata <= nxt_wdata;
            if (state == SETUP) begin
                cnt <= CNT_W'(ACCESS_CYC - 1);
            end else if ((state == ACCESS) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Output decode from the state being entered, so outputs register in step with it
    always_comb begin
        gnt0_d        = 1'b0;
        gnt1_d        = 1'b0;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        mem_address_d = '0;
        mem_we_d      = 1'b0;
        mem_MEMbus_d  = 1'b0;
        mem_BUSmem_d  = 1'b0;
        bus_oe_d      = 1'b0;
        bus_dout_d    = '0;
        case (state_nxt)
            SETUP: begin
                gnt0_d        = (nxt_port == PORT_IFETCH);
                gnt1_d        = (nxt_port == PORT_DATA);
                mem_address_d = nxt_addr;
                mem_we_d      = nxt_we;
            end
            ACCESS: begin
                gnt0_d        = (nxt_port == PORT_IFETCH);
                gnt1_d        = (nxt_port == PORT_DATA);
                mem_address_d = nxt_addr;
                if (nxt_we) begin
                    mem_we_d     = 1'b1;
                    mem_BUSmem_d = 1'b1;
                    bus_oe_d     = 1'b1;
                    bus_dout_d   = nxt_wdata;
                end else begin
                    mem_MEMbus_d = 1'b1;
                end
            end
            DONE: begin
                gnt0_d        = (nxt_port == PORT_IFETCH);
                gnt1_d        = (nxt_port == PORT_DATA);
                ack0_d        = (nxt_port == PORT_IFETCH);
                ack1_d        = (nxt_port == PORT_DATA);
                mem_address_d = nxt_addr;
                mem_we_d      = nxt_we;
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            mem_address <= '0;
            mem_we      <= 1'b0;
            mem_MEMbus  <= 1'b0;
            mem_BUSmem  <= 1'b0;
            bus_oe      <= 1'b0;
            bus_dout    <= '0;
        end else begin
            gnt0        <= gnt0_d;
            gnt1        <= gnt1_d;
            ack0        <= ack0_d;
            ack1        <= ack1_d;
            mem_address <= mem_address_d;
            mem_we      <= mem_we_d;
            mem_MEMbus  <= mem_MEMbus_d;
            mem_BUSmem  <= mem_BUSmem_d;
            bus_oe      <= bus_oe_d;
            bus_dout    <= bus_dout_d;
        end
    end

    // Read data captured on the final ACCESS edge and held until the next read
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= '0;
        end else if ((state == ACCESS) && (cnt == '0) && !lat_we) begin
            rdata <= bus_din;
        end
    end

endmodule
